// File: rtl/mul_seq_pkg.sv
// Shared types and default sizing for the sequential 32x32 multiplier.
package mul_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-and-add datapath: multiplicand, partial high word and shifting multiplier,
// with one WIDTH-bit adder whose carry-out is kept in the shift.
module mul_seq_dp
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_cap,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_nxt_acc,
  output logic [WIDTH-1:0] o_nxt_mq
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;

  assign w_addend  = r_mq[0] ? {1'b0, r_mcand} : '0;
  assign w_sum     = {1'b0, r_acc} + w_addend;
  // carry-out lands in the top of acc; sum LSB shifts into the product low word
  assign o_nxt_acc = w_sum[WIDTH:1];
  assign o_nxt_mq  = {w_sum[0], r_mq[WIDTH-1:1]};

  // i_cap parks the datapath at zero when an operation is abandoned
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cap) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_acc   <= '0;
      r_mq    <= i_b;
    end else if (i_step) begin
      r_acc   <= o_nxt_acc;
      r_mq    <= o_nxt_mq;
    end
  end

endmodule

// File: rtl/mul_seq_32.sv
// Sequencer for the iterative multiplier: start/busy/done handshake, flush abort,
// iteration counter and the held product registers.
//
// state  | meaning
// S_IDLE | waiting for start; product outputs hold the last result
// S_RUN  | one add/shift step per cycle, 32 cycles
// S_DONE | done pulse; new product visible
module mul_seq_32
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic [WIDTH-1:0] o_prod_lo
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_prod_hi;
  logic [WIDTH-1:0] r_prod_lo;

  logic             w_load;
  logic             w_step;
  logic             w_cap;
  logic             w_last;
  logic [WIDTH-1:0] w_nxt_acc;
  logic [WIDTH-1:0] w_nxt_mq;

  assign w_load = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_step = (r_state == S_RUN) && !i_flush;
  assign w_cap  = i_flush;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  mul_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_cap     (w_cap),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_nxt_acc (w_nxt_acc),
    .o_nxt_mq  (w_nxt_mq)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_prod_hi <= w_nxt_acc;
              r_prod_lo <= w_nxt_mq;
            end
          end
        end
        S_DONE: begin
          // flush here changes nothing extra: the pulse was already issued
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_prod_hi = r_prod_hi;
  assign o_prod_lo = r_prod_lo;

endmodule

// File: doc/mul_seq_32.md
# mul_seq_32

Iterative shift-and-add multiplier sequencer for the pipelined CPU's EX stage. It owns one 32-bit adder and steps it through 32 add/shift iterations to form a 64-bit unsigned product. It exposes a start/busy/done handshake so the hazard unit can stall the pipeline while a multiply is in flight. A flush input aborts the operation on branch mispredict or exception.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request a multiply; accepted only when busy==0
- flush  in  1  synchronous abort; dominates start
- a  in  WIDTH  multiplicand; sampled only on the accepting edge
- b  in  WIDTH  multiplier; sampled only on the accepting edge
- busy  out  1  high while state is RUN or DONE
- done  out  1  one-cycle pulse; product valid and new
- prod_hi  out  WIDTH  upper half of the last completed product
- prod_lo  out  WIDTH  lower half of the last completed product

## Operation
- States are IDLE, RUN and DONE.
- Internal registers:
  - mcand[WIDTH]: latched a
  - acc[WIDTH]: partial high word
  - mq[WIDTH]: multiplier, shifted into the product low word
  - cnt[CNT_W]
- IDLE, start=1 and flush=0: mcand←a, mq←b, acc←0, cnt←0, go to RUN.
- RUN, each cycle:
  - Compute sum[WIDTH:0] = {1'b0,acc} + (mq[0] ? {1'b0,mcand} : 0). The adder is WIDTH bits wide with carry-out and never truncates.
  - Shift right one bit: {acc,mq} ← {sum[WIDTH:0], mq[WIDTH-1:1]}.
  - cnt increments and wraps from 31 to 0. When cnt==WIDTH-1, the next state is DONE.
- On the RUN→DONE edge, prod_hi←next acc and prod_lo←next mq.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency is fixed at 32 RUN cycles regardless of operand values; an operand of 0 does not shorten it.
- busy=1 in RUN and DONE. start in those states is ignored, not queued.
- prod_hi and prod_lo hold their value until the next successful completion. An aborted operation never changes them.
- flush=1 in RUN or DONE: go to IDLE on the next edge. done stays 0 on that edge (a flushed DONE cycle is still the pulse already issued). The product outputs are unchanged.
- flush and start together in IDLE: stay IDLE, nothing accepted.
- Reset values: state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, acc=mq=mcand=0, cnt=0.
- rst mid-RUN returns to the reset values on the next edge with no done pulse. rst dominates flush and start.

## Timing
- Let E0 be the edge on which start is accepted.
- busy rises after E0. RUN occupies cycles 1..32. done and the new product are visible in cycle 33. busy falls after E33.
- Earliest next acceptance is E34, so a back-to-back throughput of one product per 34 cycles.
- done, busy, prod_hi and prod_lo are registered outputs with no combinational path from any input.
- The stall request to the hazard unit is start | busy, formed outside this block.

## Structure
- Shared package mul_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - the WIDTH and CNT_W default constants
- Sub-module mul_seq_dp holds mcand, acc and mq, the carry-out adder and the shift logic. Its controls are load, step and cap.
- The FSM, counter and output registers stay in mul_seq_32.

## Test plan
- a=3, b=5, start at E0: busy=1 for cycles 1..33; done=1 only in cycle 33; prod_hi=0, prod_lo=15.
- a=b=0xFFFFFFFF: prod_hi=0xFFFFFFFE, prod_lo=0x00000001. Carry-out is retained.
- Complete 7×9, then start 0x10000×0x10000 with a=b=0 driven from cycle 1 on:
  - done at 33; prod_hi=0x00000001, prod_lo=0. This proves operands are sampled only at E0.
  - start pulses during cycles 5 and 33 are ignored: no second done, and busy is low in cycle 34.
- Complete 6×7 (prod_lo=42), then start 2×2 and assert flush in cycle 10:
  - IDLE and busy=0 in cycle 11; no done ever.
  - prod_lo stays 42, prod_hi stays 0.
- rst asserted in cycle 20 of a RUN: all outputs 0 next cycle. A new start of 4×4 completes with 16 at the normal latency.
- flush and start together in IDLE: busy stays 0. Then start in the cycle after a done (E34): accepted, done at cycle 67.
